// File: rtl/xlib_avalon_pkg.sv
// Shared constants and helpers for the Avalon write-master slice.
// Defaults feed the module parameters; CW is the count width for the default BL.
package xlib_avalon_pkg;

   localparam int unsigned XL_DW = 32;
   localparam int unsigned XL_AW = 32;
   localparam int unsigned XL_BL = 8;
   localparam int unsigned CW    = XL_BL + 1;

   localparam logic [XL_DW/8-1:0] BE_ALL_ONES = {(XL_DW/8){1'b1}};

   // Wide result; callers truncate to their own count width.
   function automatic logic [31:0] f_burstcount(input logic [31:0] wlen, input int unsigned bi);
      return wlen + 32'd1 - 32'(bi);
   endfunction

endpackage

// File: rtl/xlib_avalon_wr_master_if.sv
// Beat stream from the arbiter plus the Avalon-MM burst-write port.
// The master modport is the write-master's view; slave is the environment's view.
interface xlib_avalon_wr_master_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned BL = 8
);

   logic            s_wrdy;
   logic            s_wval;
   logic [BL-1:0]   s_wlen;
   logic [AW-1:0]   s_waddr;
   logic [DW-1:0]   s_wdata;

   logic            avm_write;
   logic [AW-1:0]   avm_address;
   logic [BL:0]     avm_burstcount;
   logic [DW-1:0]   avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic            avm_waitrequest;

   modport master (
      output s_wrdy,
      input  s_wval, s_wlen, s_waddr, s_wdata,
      output avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
      input  avm_waitrequest
   );

   modport slave (
      input  s_wrdy,
      output s_wval, s_wlen, s_waddr, s_wdata,
      input  avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
      output avm_waitrequest
   );

endinterface

// File: rtl/xlib_skid2.sv
// Generic 2-entry valid/ready skid buffer with registered in_rdy.
// An empty buffer forwards the incoming word straight to the output in the same cycle.
module xlib_skid2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_val,
   output logic         in_rdy,
   input  logic [W-1:0] in_data,
   output logic         out_val,
   input  logic         out_rdy,
   output logic [W-1:0] out_data,
   output logic         nonempty
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         rdy_q, rdy_d;

   logic push, pop, empty, st_push, st_pop;

   assign empty    = (cnt_q == 2'd0);
   assign push     = in_val & rdy_q;
   assign out_val  = ~empty | push;
   assign out_data = empty ? in_data : mem_q[rd_ptr_q];
   assign pop      = out_val & out_rdy;
   assign nonempty = ~empty;

   // A push popped in the same cycle from an empty buffer never touches storage.
   assign st_push = push & ~(pop & empty);
   assign st_pop  = pop & ~empty;

   always_comb begin
      cnt_d    = cnt_q + 2'(st_push) - 2'(st_pop);
      wr_ptr_d = wr_ptr_q ^ st_push;
      rd_ptr_d = rd_ptr_q ^ st_pop;
      rdy_d    = (cnt_d != 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= rdy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (st_push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign in_rdy = rdy_q;

endmodule

// File: rtl/xlib_avalon_wr_master.sv
// Avalon-MM burst-write master fed by the write-bus arbiter's beat stream.
// Frames bursts from wlen on first beats and holds address/burstcount across the burst.
module xlib_avalon_wr_master
   import xlib_avalon_pkg::*;
#(
   parameter int unsigned DW   = XL_DW,
   parameter int unsigned AW   = XL_AW,
   parameter int unsigned BL   = XL_BL,
   parameter int unsigned BI   = 1,
   parameter int unsigned MAXB = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   xlib_avalon_wr_master_if.master bus,
   output logic                   busy,
   output logic                   err_len
);

   localparam int unsigned BCW = BL + 1;
   localparam int unsigned SW  = DW + AW + BL;

   logic          sk_val, sk_rdy, sk_nonempty;
   logic [SW-1:0] sk_data;
   logic [BL-1:0] hd_wlen;
   logic [AW-1:0] hd_waddr;
   logic [DW-1:0] hd_wdata;

   xlib_skid2 #(
      .W(SW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_val   (bus.s_wval),
      .in_rdy   (bus.s_wrdy),
      .in_data  ({bus.s_wlen, bus.s_waddr, bus.s_wdata}),
      .out_val  (sk_val),
      .out_rdy  (sk_rdy),
      .out_data (sk_data),
      .nonempty (sk_nonempty)
   );

   assign {hd_wlen, hd_waddr, hd_wdata} = sk_data;

   logic           write_q, write_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [BCW-1:0] bc_q, bc_d;
   logic [DW-1:0]  data_q, data_d;
   logic [BCW-1:0] rem_q, rem_d;
   logic           err_q, err_d;

   logic [BCW-1:0] bc_new;
   logic           len_bad, load, take;

   assign bc_new  = BCW'(f_burstcount(32'(hd_wlen), BI));
   assign len_bad = (bc_new == '0) | (bc_new > BCW'(MAXB));

   // The output register can accept a new beat when empty or when its beat leaves now.
   assign sk_rdy = ~write_q | ~bus.avm_waitrequest;
   assign load   = sk_val & sk_rdy;
   assign take   = write_q & ~bus.avm_waitrequest;

   always_comb begin
      write_d = write_q;
      addr_d  = addr_q;
      bc_d    = bc_q;
      data_d  = data_q;
      rem_d   = rem_q;
      err_d   = err_q;
      if (load) begin
         write_d = 1'b1;
         data_d  = hd_wdata;
         if (rem_q == '0) begin
            addr_d = hd_waddr;
            if (len_bad) begin
               // Illegal length: issue the beat as a single-beat burst.
               bc_d  = BCW'(1);
               rem_d = '0;
               err_d = 1'b1;
            end else begin
               bc_d  = bc_new;
               rem_d = bc_new - BCW'(1);
            end
         end else begin
            rem_d = rem_q - BCW'(1);
         end
      end else if (take) begin
         write_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         bc_q    <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         write_q <= write_d;
         addr_q  <= addr_d;
         bc_q    <= bc_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   assign bus.avm_write      = write_q;
   assign bus.avm_address    = addr_q;
   assign bus.avm_burstcount = bc_q;
   assign bus.avm_writedata  = data_q;
   assign bus.avm_byteenable = {(DW/8){1'b1}};

   assign busy    = (rem_q != '0) | write_q | sk_nonempty;
   assign err_len = err_q;

endmodule

// File: tb/tb_xlib_avalon_wr_master.sv
// Bench for xlib_avalon_wr_master: a BI=1 and a BI=0 instance share one directed stimulus,
// a burst-level queue model checks every taken beat, and literal checks pin timing.
module tb_xlib_avalon_wr_master;
   import xlib_avalon_pkg::*;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 32;
   localparam int unsigned BL   = 8;
   localparam int unsigned MAXB = 16;
   localparam int unsigned TCW  = CW;

   typedef struct packed {
      logic [AW-1:0]  a;
      logic [TCW-1:0] bc;
      logic [DW-1:0]  d;
      logic           err;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          val, wreq;
   logic [BL-1:0] wlen;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          busy1, err1, busy0, err0;

   xlib_avalon_wr_master_if #(.DW(DW), .AW(AW), .BL(BL)) bus1 ();
   xlib_avalon_wr_master_if #(.DW(DW), .AW(AW), .BL(BL)) bus0 ();

   assign bus1.s_wval = val;  assign bus0.s_wval = val;
   assign bus1.s_wlen = wlen; assign bus0.s_wlen = wlen;
   assign bus1.s_waddr = waddr; assign bus0.s_waddr = waddr;
   assign bus1.s_wdata = wdata; assign bus0.s_wdata = wdata;
   assign bus1.avm_waitrequest = wreq; assign bus0.avm_waitrequest = wreq;

   xlib_avalon_wr_master #(.DW(DW), .AW(AW), .BL(BL), .BI(1), .MAXB(MAXB)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .err_len(err1)
   );

   xlib_avalon_wr_master #(.DW(DW), .AW(AW), .BL(BL), .BI(0), .MAXB(MAXB)) u_dut_bi0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .err_len(err0)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Burst-level model state per instance (index = instance BI).
   int            mrem [2];
   int            mbc  [2];
   logic [AW-1:0] maddr [2];
   logic          merr [2];
   beat_t         mq0 [$];
   beat_t         mq1 [$];
   logic          stall_p [2];
   beat_t         prev [2];

   // Per-scenario logs used by the literal checks.
   int            acc_cyc [$];
   int            take_cyc [$];
   logic [AW-1:0] take_a [$];
   int            take_bc [$];
   logic [AW-1:0] take_a0 [$];
   int            take_bc0 [$];
   int            rdy_low;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic dut_step(input int k, input logic w, input logic rdy, input logic bsy,
                           input logic er, input logic [AW-1:0] a, input logic [TCW-1:0] bc,
                           input logic [DW-1:0] d, input logic [DW/8-1:0] be);
      beat_t e;
      int    sz;
      int    n;
      if (!rst_n) begin
         chk($sformatf("rst_write%0d", k), w, 1'b0);
         chk($sformatf("rst_busy%0d", k), bsy, 1'b0);
         chk($sformatf("rst_rdy%0d", k), rdy, 1'b0);
         chk($sformatf("rst_err%0d", k), er, 1'b0);
         mrem[k] = 0; merr[k] = 1'b0; stall_p[k] = 1'b0;
         if (k == 1) mq1.delete(); else mq0.delete();
         return;
      end
      sz = (k == 1) ? mq1.size() : mq0.size();
      chk($sformatf("busy%0d", k), bsy, (sz != 0) || (mrem[k] != 0));
      if (stall_p[k]) begin
         chk($sformatf("hold_write%0d", k), w, 1'b1);
         chk($sformatf("hold_addr%0d", k), a, prev[k].a);
         chk($sformatf("hold_bc%0d", k), bc, prev[k].bc);
         chk($sformatf("hold_data%0d", k), d, prev[k].d);
      end
      if (w && !wreq) begin
         if (sz == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_beat%0d: got data 0x%0h, required no beat", k, d);
         end else begin
            if (k == 1) e = mq1.pop_front(); else e = mq0.pop_front();
            chk($sformatf("addr%0d", k), a, e.a);
            chk($sformatf("bc%0d", k), bc, e.bc);
            chk($sformatf("data%0d", k), d, e.d);
            chk($sformatf("err%0d", k), er, e.err);
            chk($sformatf("be%0d", k), be, BE_ALL_ONES);
         end
         if (k == 1) begin
            take_cyc.push_back(cyc); take_a.push_back(a); take_bc.push_back(int'(bc));
         end else begin
            take_a0.push_back(a); take_bc0.push_back(int'(bc));
         end
      end
      stall_p[k] = w && wreq;
      prev[k].a = a; prev[k].bc = bc; prev[k].d = d; prev[k].err = er;
      if (val && rdy) begin
         if (mrem[k] == 0) begin
            n = (int'(wlen) + 1 - k) % (1 << TCW);
            if (n == 0 || n > int'(MAXB)) begin
               merr[k] = 1'b1;
               e.a = waddr; e.bc = TCW'(1);
            end else begin
               mbc[k] = n; maddr[k] = waddr; mrem[k] = n - 1;
               e.a = waddr; e.bc = TCW'(n);
            end
         end else begin
            mrem[k]--;
            e.a = maddr[k]; e.bc = TCW'(mbc[k]);
         end
         e.d = wdata; e.err = merr[k];
         if (k == 1) begin
            mq1.push_back(e); acc_cyc.push_back(cyc);
         end else begin
            mq0.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      dut_step(1, bus1.avm_write, bus1.s_wrdy, busy1, err1, bus1.avm_address,
               bus1.avm_burstcount, bus1.avm_writedata, bus1.avm_byteenable);
      dut_step(0, bus0.avm_write, bus0.s_wrdy, busy0, err0, bus0.avm_address,
               bus0.avm_burstcount, bus0.avm_writedata, bus0.avm_byteenable);
      if (rst_n && !bus1.s_wrdy) rdy_low++;
   end

   task automatic clear_logs();
      acc_cyc.delete(); take_cyc.delete(); take_a.delete(); take_bc.delete();
      take_a0.delete(); take_bc0.delete(); rdy_low = 0;
   endtask

   task automatic cyc_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      val = 1'b0; wreq = 1'b0; rst_n = 1'b0;
      repeat (3) cyc_step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_before_first_clk", bus1.s_wrdy, 1'b0);
      @(negedge clk);
      chk("rdy_after_first_clk", bus1.s_wrdy, 1'b1);
      cyc_step();
      clear_logs();
   endtask

   task automatic send_beat(input logic [BL-1:0] l, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      int t = 0;
      val = 1'b1; wlen = l; waddr = a; wdata = d;
      @(negedge clk);
      while (!bus1.s_wrdy && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (t >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got no s_wrdy in 200 cycles, required acceptance");
      end
      cyc_step();
   endtask

   // Non-first beats carry junk wlen/addr, which the design must ignore.
   task automatic send_burst(input int n, input logic [BL-1:0] l, input logic [AW-1:0] a,
                             input logic [DW-1:0] dbase);
      for (int i = 0; i < n; i++) begin
         if (i == 0) send_beat(l, a, dbase);
         else send_beat(8'hA5, 32'hDEAD_0000 | AW'(i), dbase + DW'(i));
      end
   endtask

   task automatic idle(input int n);
      val = 1'b0;
      repeat (n) cyc_step();
   endtask

   initial begin
      rst_n = 1'b0; val = 1'b0; wreq = 1'b0; wlen = '0; waddr = '0; wdata = '0;
      rdy_low = 0;

      // Single 4-beat burst, no stalls.
      do_reset();
      send_burst(4, 8'd4, 32'h100, 32'h1000);
      idle(3);
      chk("s1_beats", take_cyc.size(), 4);
      if (take_cyc.size() == 4 && acc_cyc.size() == 4) begin
         chk("s1_latency", take_cyc[0] - acc_cyc[0], 1);
         chk("s1_consecutive", take_cyc[3] - take_cyc[0], 3);
         chk("s1_bc", take_bc[3], 4);
         chk("s1_addr", take_a[3], 32'h100);
      end
      chk("s1_busy_done", busy1, 1'b0);

      // 8-beat burst with waitrequest high for four cycles.
      do_reset();
      fork
         send_burst(8, 8'd8, 32'h2000, 32'h2000);
         begin
            repeat (2) cyc_step();
            wreq = 1'b1;
            repeat (4) cyc_step();
            wreq = 1'b0;
         end
      join
      idle(4);
      chk("s2_beats", take_cyc.size(), 8);
      if (take_cyc.size() == 8) chk("s2_last_take", take_cyc[7] - acc_cyc[0], 12);
      chk("s2_rdy_low_cycles", rdy_low, 3);

      // BI=0 instance: wlen 7 -> 8 beats, wlen 0 -> 1 beat, then a new burst at 0x200.
      do_reset();
      send_burst(8, 8'd7, 32'h300, 32'h3000);
      send_burst(1, 8'd0, 32'h340, 32'h3400);
      send_burst(4, 8'd3, 32'h200, 32'h3800);
      idle(4);
      chk("s3_beats0", take_bc0.size(), 13);
      if (take_bc0.size() == 13) begin
         chk("s3_bc8", take_bc0[0], 8);
         chk("s3_addr_held", take_a0[7], 32'h300);
         chk("s3_bc1", take_bc0[8], 1);
         chk("s3_bc4", take_bc0[9], 4);
         chk("s3_addr_relatch", take_a0[9], 32'h200);
      end

      // Upstream gap after beat 2 of a 4-beat burst.
      do_reset();
      send_burst(2, 8'd4, 32'h400, 32'h4000);
      val = 1'b0;
      repeat (2) cyc_step();
      @(negedge clk);
      chk("s4_gap_write", bus1.avm_write, 1'b0);
      chk("s4_gap_busy", busy1, 1'b1);
      cyc_step();
      send_beat(8'hA5, 32'hDEAD_0003, 32'h4002);
      send_beat(8'hA5, 32'hDEAD_0004, 32'h4003);
      idle(3);
      chk("s4_beats", take_cyc.size(), 4);
      if (take_cyc.size() == 4) begin
         chk("s4_gap_len", take_cyc[2] - take_cyc[1], 4);
         chk("s4_addr3", take_a[2], 32'h400);
         chk("s4_addr4", take_a[3], 32'h400);
         chk("s4_bc3", take_bc[2], 4);
      end

      // Illegal lengths with BI=1: wlen 0 and wlen MAXB+1.
      do_reset();
      send_beat(8'd0, 32'h500, 32'h5000);
      send_beat(8'(MAXB + 1), 32'h600, 32'h5001);
      send_burst(2, 8'd2, 32'h700, 32'h5002);
      idle(3);
      chk("s5_beats", take_bc.size(), 4);
      if (take_bc.size() == 4) begin
         chk("s5_bc_err0", take_bc[0], 1);
         chk("s5_bc_err1", take_bc[1], 1);
         chk("s5_addr_err1", take_a[1], 32'h600);
         chk("s5_bc_legal", take_bc[3], 2);
      end
      chk("s5_err_sticky", err1, 1'b1);

      // Reset after beat 3 of 8, then a fresh 2-beat burst.
      do_reset();
      send_burst(3, 8'd8, 32'h800, 32'h8000);
      do_reset();
      send_burst(2, 8'd2, 32'h900, 32'h9000);
      idle(3);
      chk("s6_beats", take_bc.size(), 2);
      if (take_bc.size() == 2) begin
         chk("s6_bc", take_bc[0], 2);
         chk("s6_addr", take_a[1], 32'h900);
      end
      chk("s6_busy_done", busy1, 1'b0);
      chk("s6_err_clear", err1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
